// File: rtl/chacha_pkg.sv
// Shared ChaCha20 types and constants for the quarter-round core and its consumers.
package chacha_pkg;

   localparam int W      = 32;
   localparam int NWORDS = 16;

   typedef logic [W-1:0]    word_t;
   typedef word_t [3:0][3:0] matrix_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_DRAIN_BLK,
      ST_DRAIN_MSG
   } state_t;

   // "expand 32-byte k" words that open every ChaCha20 input matrix
   function automatic word_t chacha_const(input int idx);
      case (idx)
         0:       return 32'h61707865;
         1:       return 32'h3320646e;
         2:       return 32'h79622d32;
         default: return 32'h6b206574;
      endcase
   endfunction

endpackage

// File: rtl/chacha_ks_word.sv
// Keystream word k of a block: feed-forward add of the post-round and original matrices.
module chacha_ks_word
   import chacha_pkg::*;
(
   input  logic [3:0] k,
   input  matrix_t    work,
   input  matrix_t    init,
   output word_t      ks
);

   logic [1:0] row;
   logic [1:0] col;

   // Matrices are stored reversed, so word 0 lives at [3][3]; the carry out of the add is dropped.
   assign row = ~k[3:2];
   assign col = ~k[1:0];
   assign ks  = work[row][col] + init[row][col];

endmodule

// File: rtl/chacha_keystream_xor.sv
// Captures a finished ChaCha20 block and XORs its 16 keystream words onto a plaintext stream.
module chacha_keystream_xor
   import chacha_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         blk_valid,
   input  matrix_t      work_in,
   input  matrix_t      init_in,
   output logic         blk_ack,
   output logic         blk_done,
   input  logic [W-1:0] pt_data,
   input  logic         pt_valid,
   input  logic         pt_last,
   output logic         pt_ready,
   output logic [W-1:0] ct_data,
   output logic         ct_valid,
   output logic         ct_last,
   input  logic         ct_ready,
   output logic         msg_done,
   output logic [31:0]  blk_count
);

   localparam logic [3:0] LAST_IDX = 4'(NWORDS - 1);

   state_t     state;
   state_t     state_next;
   logic [3:0] idx;
   matrix_t    work_q;
   matrix_t    init_q;
   word_t      ks;
   logic       pt_hs;
   logic       ct_hs;
   logic       draining;

   chacha_ks_word u_ks_word (
      .k    (idx),
      .work (work_q),
      .init (init_q),
      .ks   (ks)
   );

   assign pt_hs    = pt_valid & pt_ready;
   assign ct_hs    = ct_valid & ct_ready;
   assign draining = (state == ST_DRAIN_BLK) || (state == ST_DRAIN_MSG);

   // NOTE: every output of this block is given a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      pt_ready   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (blk_valid) state_next = ST_STREAM;
         end
         ST_STREAM: begin
            // one-entry output register: accept only if it is empty or emptying this cycle
            pt_ready = pt_valid & (~ct_valid | ct_ready);
            if (pt_ready) begin
               if (pt_last)              state_next = ST_DRAIN_MSG;
               else if (idx == LAST_IDX) state_next = ST_DRAIN_BLK;
            end
         end
         ST_DRAIN_BLK, ST_DRAIN_MSG: begin
            if (ct_hs) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         work_q    <= '0;
         init_q    <= '0;
         ct_data   <= '0;
         ct_valid  <= 1'b0;
         ct_last   <= 1'b0;
         blk_ack   <= 1'b0;
         blk_done  <= 1'b0;
         msg_done  <= 1'b0;
         blk_count <= '0;
      end else begin
         state    <= state_next;
         blk_ack  <= 1'b0;
         blk_done <= 1'b0;
         msg_done <= 1'b0;

         if (state == ST_IDLE && blk_valid) begin
            work_q  <= work_in;
            init_q  <= init_in;
            idx     <= '0;
            blk_ack <= 1'b1;
         end

         if (pt_hs) begin
            ct_data  <= ks ^ pt_data;
            ct_last  <= pt_last;
            ct_valid <= 1'b1;
            // idx is frozen on the terminating word so a message drain can tell whether word 15 went out
            if (state_next == ST_STREAM) idx <= idx + 4'd1;
         end else if (ct_hs) begin
            ct_valid <= 1'b0;
         end

         if (draining && ct_hs) begin
            blk_count <= blk_count + 32'd1;
            blk_done  <= (state == ST_DRAIN_BLK) || (idx == LAST_IDX);
            msg_done  <= (state == ST_DRAIN_MSG);
         end
      end
   end

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// Directed bench for chacha_keystream_xor: RFC 7539 block, backpressure, early end, wrap, reset abort.
module tb_chacha_keystream_xor;
   import chacha_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        blk_valid;
   matrix_t     work_in;
   matrix_t     init_in;
   logic        blk_ack;
   logic        blk_done;
   logic [31:0] pt_data;
   logic        pt_valid;
   logic        pt_last;
   logic        pt_ready;
   logic [31:0] ct_data;
   logic        ct_valid;
   logic        ct_last;
   logic        ct_ready;
   logic        msg_done;
   logic [31:0] blk_count;

   int vectors     = 0;
   int miscompares = 0;

   // RFC 7539 2.3.2 state after 20 rounds, and the serialised block after the feed-forward add
   logic [31:0] rfc_work [16] = '{
      32'h837778ab, 32'he238d763, 32'ha67ae21e, 32'h5950bb2f,
      32'hc4f2d0c7, 32'hfc62bb2f, 32'h8fa018fc, 32'h3f5ec7b7,
      32'h335271c2, 32'hf29489f3, 32'heabda8fc, 32'h82e46ebd,
      32'hd19c12b4, 32'hb04e16de, 32'h9e83d0cb, 32'h4e3c50a2};
   logic [31:0] rfc_key_nonce [12] = '{
      32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
      32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
      32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
   logic [31:0] rfc_ks [16] = '{
      32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
      32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
      32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
      32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

   logic [31:0] src_work [16];
   logic [31:0] src_init [16];
   logic [31:0] exp_ks   [16];
   logic [31:0] pt_pat   [16];
   logic [31:0] bc_exp;

   always #5 clk = ~clk;

   chacha_keystream_xor dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .blk_valid (blk_valid),
      .work_in   (work_in),
      .init_in   (init_in),
      .blk_ack   (blk_ack),
      .blk_done  (blk_done),
      .pt_data   (pt_data),
      .pt_valid  (pt_valid),
      .pt_last   (pt_last),
      .pt_ready  (pt_ready),
      .ct_data   (ct_data),
      .ct_valid  (ct_valid),
      .ct_last   (ct_last),
      .ct_ready  (ct_ready),
      .msg_done  (msg_done),
      .blk_count (blk_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic load_rfc();
      for (int k = 0; k < 16; k++) begin
         src_work[k] = rfc_work[k];
         src_init[k] = (k < 4) ? chacha_const(k) : rfc_key_nonce[k-4];
         exp_ks[k]   = rfc_ks[k];
         pt_pat[k]   = 32'h0;
      end
   endtask

   task automatic load_mats();
      for (int k = 0; k < 16; k++) begin
         work_in[3-k/4][3-k%4] = src_work[k];
         init_in[3-k/4][3-k%4] = src_init[k];
      end
   endtask

   // One block from capture to drain; last_at/stall_at/abort_at < 0 disable that feature.
   task automatic run_block(input int last_at, input int stall_at, input bit inject, input int abort_at);
      int n_words;
      int pt_idx;
      int ct_idx;
      int stalls;
      int fin_iter;
      bit finished;
      n_words  = (last_at >= 0) ? last_at + 1 : 16;
      pt_idx   = 0;
      ct_idx   = 0;
      stalls   = 0;
      fin_iter = -1;
      finished = 1'b0;
      blk_valid = 1'b1;
      @(posedge clk); #1;
      blk_valid = 1'b0;
      chk("blk_ack_pulse", 32'(blk_ack), 32'd1);
      for (int iter = 0; iter < 200 && !finished; iter++) begin
         if (abort_at >= 0 && pt_idx == abort_at + 1) begin
            rst_n    = 1'b0;
            pt_valid = 1'b0;
            @(posedge clk); #1;
            chk("abort_ct_valid", 32'(ct_valid), 32'd0);
            chk("abort_ct_data", ct_data, 32'd0);
            chk("abort_blk_count", blk_count, 32'd0);
            rst_n    = 1'b1;
            pt_valid = 1'b1;
            #1;
            chk("abort_idle_pt_ready", 32'(pt_ready), 32'd0);
            pt_valid = 1'b0;
            bc_exp   = 32'd0;
            return;
         end
         pt_valid = (pt_idx < n_words);
         pt_data  = 32'h0;
         if (pt_idx < n_words) pt_data = pt_pat[pt_idx];
         pt_last  = (pt_idx == last_at);
         ct_ready = !(ct_valid && ct_idx == stall_at && stalls < 3);
         blk_valid = inject && iter == 4;
         if (inject && iter == 4) begin
            for (int k = 0; k < 16; k++) work_in[3-k/4][3-k%4] = rfc_work[k];
         end
         #1;
         if (iter > 0) chk("no_blk_ack", 32'(blk_ack), 32'd0);
         chk("no_blk_done", 32'(blk_done), 32'd0);
         chk("no_msg_done", 32'(msg_done), 32'd0);
         if (!ct_ready) begin
            chk("hold_ct_data", ct_data, exp_ks[ct_idx] ^ pt_pat[ct_idx]);
            chk("hold_pt_ready", 32'(pt_ready), 32'd0);
            stalls++;
         end
         if (ct_valid && ct_ready) begin
            chk($sformatf("ct_data_w%0d", ct_idx), ct_data, exp_ks[ct_idx] ^ pt_pat[ct_idx]);
            chk($sformatf("ct_last_w%0d", ct_idx), 32'(ct_last), 32'(ct_idx == last_at));
            ct_idx++;
            if (ct_idx == n_words) begin
               finished = 1'b1;
               fin_iter = iter;
            end
         end
         if (pt_ready) pt_idx++;
         @(posedge clk); #1;
      end
      blk_valid = 1'b0;
      chk("words_consumed", ct_idx, n_words);
      chk("stream_cycles", fin_iter, n_words + stalls);
      if (finished) bc_exp++;
      chk("end_blk_done", 32'(blk_done), 32'(n_words == 16));
      chk("end_msg_done", 32'(msg_done), 32'(last_at >= 0));
      chk("end_blk_count", blk_count, bc_exp);
      chk("end_ct_valid", 32'(ct_valid), 32'd0);
      pt_valid = 1'b1;
      pt_last  = 1'b0;
      #1;
      chk("end_idle_pt_ready", 32'(pt_ready), 32'd0);
      pt_valid = 1'b0;
      @(posedge clk); #1;
      chk("blk_done_one_cycle", 32'(blk_done), 32'd0);
      chk("msg_done_one_cycle", 32'(msg_done), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bc_exp    = 32'd0;
      rst_n     = 1'b0;
      blk_valid = 1'b1;
      pt_data   = 32'h0;
      pt_valid  = 1'b1;
      pt_last   = 1'b0;
      ct_ready  = 1'b1;
      load_rfc();
      load_mats();

      // reset held with blk_valid high: nothing may be captured or driven
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pt_ready", 32'(pt_ready), 32'd0);
      chk("rst_ct_valid", 32'(ct_valid), 32'd0);
      chk("rst_ct_last", 32'(ct_last), 32'd0);
      chk("rst_ct_data", ct_data, 32'd0);
      chk("rst_blk_ack", 32'(blk_ack), 32'd0);
      chk("rst_blk_done", 32'(blk_done), 32'd0);
      chk("rst_msg_done", 32'(msg_done), 32'd0);
      chk("rst_blk_count", blk_count, 32'd0);
      pt_valid = 1'b0;

      // RFC block captured on the very edge reset is released (blk_valid still high)
      rst_n = 1'b1;
      run_block(-1, -1, 1'b0, -1);

      // same block with word 5 held for three cycles
      run_block(-1, 5, 1'b0, -1);

      // message ends on word 6, then a fresh block ending exactly on word 15
      run_block(6, -1, 1'b0, -1);
      run_block(15, -1, 1'b0, -1);

      // modulo-2^32 wrap: 1 + ffffffff = 0, so ciphertext equals plaintext; stray blk_valid mid-stream
      for (int k = 0; k < 16; k++) begin
         src_work[k] = 32'h00000001;
         src_init[k] = 32'hffffffff;
         exp_ks[k]   = 32'h00000000;
         pt_pat[k]   = 32'ha5a5a5a5;
      end
      load_mats();
      run_block(-1, -1, 1'b1, -1);

      // reset while word 9 sits in the output register
      load_rfc();
      load_mats();
      run_block(-1, -1, 1'b0, 9);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/chacha_keystream_xor.md
Name: chacha_keystream_xor

Overview:
- Downstream consumer of the PerformQround block.
- On each block-ready event it captures the post-round working matrix and the original input matrix, applies the ChaCha20 feed-forward add, and serialises the 16 keystream words.
- Each keystream word is XORed with one 32-bit plaintext word from a valid/ready stream, producing ciphertext on a registered valid/ready output.
- It sits between the quarter-round core and the AEAD data path (and the Poly1305 input).

Parameters:
W, 32, word width; equals the width of word_t.
NWORDS, 16, keystream words per block; fixed to 4x4.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous active-low reset.
blk_valid  in  1  block ready from the quarter-round core (blockready); a one-cycle pulse is sufficient.
work_in  in  word_t[3:0][3:0]  post-round matrix (chachamatrixOUT).
init_in  in  word_t[3:0][3:0]  original input matrix (chachamatrixIN).
blk_ack  out  1  one-cycle pulse when a block is captured.
blk_done  out  1  one-cycle pulse when keystream word 15 is consumed.
pt_data  in  32  plaintext word.
pt_valid  in  1  plaintext valid.
pt_last  in  1  final plaintext word of the message.
pt_ready  out  1  plaintext accepted this cycle.
ct_data  out  32  ciphertext word.
ct_valid  out  1  ciphertext valid.
ct_last  out  1  mirrors the pt_last of this word.
ct_ready  in  1  downstream ready.
msg_done  out  1  one-cycle pulse when the word carrying ct_last is consumed.
blk_count  out  32  blocks fully or partially consumed since reset; wraps modulo 2^32.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, word index 0, captured registers 0. All outputs 0 (pt_ready, ct_valid, ct_last, ct_data, blk_ack, blk_done, msg_done, blk_count). Reset mid-stream aborts the block; any held ct word is dropped.
- Word mapping: matrices are stored reversed. Keystream word k = work_in[3-k/4][3-k%4] + init_in[3-k/4][3-k%4]. Word 0 is at [3][3].
- Arithmetic: the add is modulo 2^32, carry discarded. XOR is bitwise.
- States:
  - IDLE: pt_ready=0. If blk_valid=1, capture work_in and init_in, pulse blk_ack next cycle, and go to STREAM with index 0.
  - STREAM: pt_ready = pt_valid & (~ct_valid | ct_ready), i.e. a one-entry output register. On a pt handshake: ct_data <= (work[k]+init[k]) ^ pt_data, ct_last <= pt_last, ct_valid <= 1, index k+1.
    - Handshake at k=15 with pt_last=0: go to DRAIN_BLK.
    - Handshake with pt_last=1 at any k: go to DRAIN_MSG; the remaining keystream of the block is discarded.
  - DRAIN_BLK / DRAIN_MSG: pt_ready=0. When the ct handshake completes: pulse blk_done (DRAIN_BLK) or msg_done (DRAIN_MSG; also pulse blk_done when k was 15), increment blk_count, then go to IDLE.
- Latency: one cycle from pt handshake to ct_valid. Full throughput of one word per cycle while ct_ready=1.
- Handshake rules:
  - ct_data and ct_last are held stable while ct_valid=1 and ct_ready=0.
  - ct_valid is never dropped without a handshake.
- Simultaneous events:
  - blk_valid outside IDLE is ignored; the captured matrix is not overwritten.
  - ct handshake and pt handshake in the same STREAM cycle: the register reloads and ct_valid stays 1.
- Capture: blk_valid in IDLE on the same cycle as reset deassert is captured.

Decomposition:
- Shared package (chacha_pkg): word_t, the 4x4 matrix typedef, NWORDS, and the ChaCha constants 61707865/3320646e/79622d32/6b206574.
- Sub-module chacha_ks_word: combinational index-to-word mux plus adder (k, work, init -> keystream word). It is reused by the Poly1305 key-generation path.
- FSM and output register stay in the top.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with blk_valid=1 -> all outputs 0, state IDLE, nothing captured.
- RFC 7539 §2.3.2 vector (key 00..1f, nonce 000000090000004a00000000, counter 1), using the core's output as work_in, pt=0 for 16 words, ct_ready=1:
  - ct words, one per cycle, k=0 is e4e7f110 and k=1 is 15593bd1, with k=15 = 4e3c50a2.
  - blk_done one cycle after word 15; blk_count=1.
- Backpressure: same vector, ct_ready=0 for 3 cycles while word 5 is held -> ct_data is constant, pt_ready=0, no word lost or duplicated, and the final sequence is identical.
- Early termination: pt_last=1 on word 6 -> ct_last=1 on word 6, msg_done pulse, blk_done=0, IDLE, blk_count+1. The next blk_valid restarts at word 0.
- Wrap and ignore: work=00000001, init=ffffffff everywhere, pt=a5a5a5a5 -> ct=a5a5a5a5. A blk_valid pulse during STREAM leaves the output unchanged.
- Reset at word 9 -> ct_valid=0 next cycle, IDLE, blk_count=0.
